// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI link-side arbiter: state codes, command
// prefixes, round-robin pointer values and request bit positions.
package ulpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT_RD = 3'd1,
        ST_GRANT_WR = 3'd2,
        ST_TURN_IN  = 3'd3,
        ST_PHY_OWN  = 3'd4,
        ST_TURN_OUT = 3'd5,
        ST_ABORT    = 3'd6
    } arb_state_e;

    localparam logic [1:0] CMD_REG_WRITE = 2'b10;
    localparam logic [1:0] CMD_REG_READ  = 2'b11;

    localparam int TURNAROUND_CYCLES = 1;

    localparam logic PTR_READ  = 1'b0;
    localparam logic PTR_WRITE = 1'b1;

    localparam int REQ_RD = 0;
    localparam int REQ_WR = 1;

endpackage

// File: rtl/ulpi_rr_pick.sv
// Two-way round-robin selector: the pointer names which requester is
// preferred when both are asking; a lone requester always wins.
module ulpi_rr_pick
    import ulpi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (ptr == PTR_READ) begin
            if (req[REQ_RD]) begin
                gnt[REQ_RD] = 1'b1;
            end else if (req[REQ_WR]) begin
                gnt[REQ_WR] = 1'b1;
            end
        end else begin
            if (req[REQ_WR]) begin
                gnt[REQ_WR] = 1'b1;
            end else if (req[REQ_RD]) begin
                gnt[REQ_RD] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ulpi_bus_arbiter.sv
// Owns the ULPI pins and shares them between the register read/write engines
// and PHY-driven traffic, with turnaround cycles on every DIR edge.
module ulpi_bus_arbiter
    import ulpi_pkg::*;
#(
    parameter int NXT_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_req,
    input  logic       wr_req,
    output logic       rd_start,
    output logic       wr_start,
    input  logic       rd_busy,
    input  logic       wr_busy,
    input  logic [7:0] rd_dout,
    input  logic [7:0] wr_dout,
    input  logic       rd_stp,
    input  logic       wr_stp,
    output logic       eng_abort,
    input  logic       DIR,
    input  logic       NXT,
    input  logic [7:0] ULPI_DATA_IN,
    output logic [7:0] ULPI_DATA_OUT,
    output logic       STP,
    output logic [7:0] rxcmd,
    output logic       rxcmd_valid,
    output logic       timeout_err,
    output logic [2:0] dbg_state
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(NXT_TIMEOUT);

    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             nxt_seen_q, nxt_seen_d;
    logic             busy_prev_q, busy_prev_d;
    logic             rd_start_q, rd_start_d;
    logic             wr_start_q, wr_start_d;
    logic [7:0]       rxcmd_q, rxcmd_d;
    logic             rxcmd_valid_q, rxcmd_valid_d;
    logic             timeout_err_q, timeout_err_d;

    logic [1:0]       gnt;
    logic             eng_busy;
    logic [7:0]       data_out;
    logic             stp_out;
    logic             abort_out;

    ulpi_rr_pick u_rr_pick (
        .req ({wr_req, rd_req}),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign eng_busy = (state_q == ST_GRANT_WR) ? wr_busy : rd_busy;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        nxt_seen_d    = nxt_seen_q;
        busy_prev_d   = busy_prev_q;
        rd_start_d    = 1'b0;
        wr_start_d    = 1'b0;
        rxcmd_d       = rxcmd_q;
        rxcmd_valid_d = 1'b0;
        timeout_err_d = timeout_err_q;
        data_out      = 8'h00;
        stp_out       = 1'b0;
        abort_out     = 1'b0;
        cnt_inc       = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                nxt_seen_d  = 1'b0;
                busy_prev_d = 1'b0;
                if (DIR) begin
                    state_d = ST_TURN_IN;
                end else if (gnt[REQ_RD]) begin
                    state_d    = ST_GRANT_RD;
                    rd_start_d = 1'b1;
                end else if (gnt[REQ_WR]) begin
                    state_d    = ST_GRANT_WR;
                    wr_start_d = 1'b1;
                end
            end

            ST_GRANT_RD, ST_GRANT_WR: begin
                data_out    = (state_q == ST_GRANT_WR) ? wr_dout : rd_dout;
                stp_out     = (state_q == ST_GRANT_WR) ? wr_stp : rd_stp;
                busy_prev_d = eng_busy;
                // DIR before NXT means the PHY took the bus over our TXCMD.
                if (!nxt_seen_q && DIR) begin
                    data_out  = 8'h00;
                    abort_out = 1'b1;
                    state_d   = ST_TURN_IN;
                end else if (busy_prev_q && !eng_busy) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~ptr_q;
                end else if (!nxt_seen_q) begin
                    if (NXT) begin
                        nxt_seen_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TIMEOUT_LIM) begin
                            state_d = ST_ABORT;
                        end
                    end
                end
            end

            ST_ABORT: begin
                stp_out       = 1'b1;
                abort_out     = 1'b1;
                timeout_err_d = 1'b1;
                state_d       = ST_IDLE;
            end

            ST_TURN_IN: begin
                state_d = DIR ? ST_PHY_OWN : ST_TURN_OUT;
            end

            ST_PHY_OWN: begin
                if (!DIR) begin
                    state_d = ST_TURN_OUT;
                end else if (!NXT) begin
                    rxcmd_d       = ULPI_DATA_IN;
                    rxcmd_valid_d = 1'b1;
                end
            end

            ST_TURN_OUT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_READ;
            cnt_q         <= '0;
            nxt_seen_q    <= 1'b0;
            busy_prev_q   <= 1'b0;
            rd_start_q    <= 1'b0;
            wr_start_q    <= 1'b0;
            rxcmd_q       <= 8'h00;
            rxcmd_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            nxt_seen_q    <= nxt_seen_d;
            busy_prev_q   <= busy_prev_d;
            rd_start_q    <= rd_start_d;
            wr_start_q    <= wr_start_d;
            rxcmd_q       <= rxcmd_d;
            rxcmd_valid_q <= rxcmd_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rd_start      = rd_start_q;
    assign wr_start      = wr_start_q;
    assign eng_abort     = abort_out;
    assign ULPI_DATA_OUT = data_out;
    assign STP           = stp_out;
    assign rxcmd         = rxcmd_q;
    assign rxcmd_valid   = rxcmd_valid_q;
    assign timeout_err   = timeout_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ulpi_bus_arbiter.sv
// Randomized scenario bench for ulpi_bus_arbiter: each scenario starts on an
// idle link and its expected pin/strobe timeline is derived from its parameters.
module tb_ulpi_bus_arbiter;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_req, wr_req, rd_busy, wr_busy, rd_stp, wr_stp, DIR, NXT;
    logic [7:0] rd_dout, wr_dout, ULPI_DATA_IN;
    logic       rd_start, wr_start, eng_abort, STP, rxcmd_valid, timeout_err;
    logic [7:0] ULPI_DATA_OUT, rxcmd;
    logic [2:0] dbg_state;

    int         n_checks = 0;
    int         n_pass   = 0;

    // reference model state
    logic       want_rd = 1'b0;
    logic       want_wr = 1'b0;
    logic       ptr_wr_m = 1'b0;
    logic       tmo_m = 1'b0;
    logic       rx_pend = 1'b0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ulpi_bus_arbiter #(.NXT_TIMEOUT(T), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req        (rd_req),
        .wr_req        (wr_req),
        .rd_start      (rd_start),
        .wr_start      (wr_start),
        .rd_busy       (rd_busy),
        .wr_busy       (wr_busy),
        .rd_dout       (rd_dout),
        .wr_dout       (wr_dout),
        .rd_stp        (rd_stp),
        .wr_stp        (wr_stp),
        .eng_abort     (eng_abort),
        .DIR           (DIR),
        .NXT           (NXT),
        .ULPI_DATA_IN  (ULPI_DATA_IN),
        .ULPI_DATA_OUT (ULPI_DATA_OUT),
        .STP           (STP),
        .rxcmd         (rxcmd),
        .rxcmd_valid   (rxcmd_valid),
        .timeout_err   (timeout_err),
        .dbg_state     (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic zero_inputs();
        rd_req = 1'b0; wr_req = 1'b0; rd_busy = 1'b0; wr_busy = 1'b0;
        rd_stp = 1'b0; wr_stp = 1'b0; DIR = 1'b0; NXT = 1'b0;
        rd_dout = 8'h00; wr_dout = 8'h00; ULPI_DATA_IN = 8'h00;
    endtask

    // Check one cycle at the falling edge, then advance the RXCMD scoreboard.
    task automatic step(input logic [7:0] e_dout, input logic e_stp, input logic e_abort,
                        input logic e_rds, input logic e_wrs, input logic cap);
        @(negedge clk);
        check("pins", 32'({ULPI_DATA_OUT, STP}), 32'({e_dout, e_stp}));
        check("ctrl", 32'({eng_abort, rd_start, wr_start, timeout_err}),
              32'({e_abort, e_rds, e_wrs, tmo_m}));
        if (rx_pend && exp_q.size() > 0) last_rx = exp_q.pop_front();
        check("rx", 32'({rxcmd, rxcmd_valid}), 32'({last_rx, rx_pend}));
        rx_pend = cap;
        if (cap) exp_q.push_back(ULPI_DATA_IN);
    endtask

    // One engine grant: completes normally, times out, or is aborted by the PHY.
    task automatic engine_scn();
        int         r, mode, nd, bl, pa, h, s, len;
        logic       e, turn, busy_v, nxt_v, dir_v, stp_v;
        logic       in_grant, abort_cyc, tmo_cyc, cap;
        logic [7:0] e_dout, exp_dout;
        if (want_rd && want_wr) e = ptr_wr_m;
        else                    e = want_wr;
        r    = $urandom_range(0, 9);
        mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
        nd   = $urandom_range(1, T - 1);
        bl   = nd + $urandom_range(1, 3);
        pa   = $urandom_range(0, T - 1);
        h    = $urandom_range(1, 4);
        s    = pa + 1;
        turn = 1'($urandom_range(0, 1));
        e_dout = 8'($urandom);
        len  = (mode == 0) ? bl + 3 : (mode == 1) ? T + 2 : s + h + 2;
        for (int t = 0; t < len; t++) begin
            @(posedge clk); #1;
            rd_req = want_rd && !(e == 1'b0 && t >= 1);
            wr_req = want_wr && !(e == 1'b1 && t >= 1);
            case (mode)
                0: begin
                    busy_v = (t >= 2 && t <= bl + 1);
                    nxt_v  = (t == nd + 1);
                    dir_v  = turn && t >= nd + 2 && t <= bl + 1;
                end
                1: begin
                    busy_v = (t >= 2 && t <= T + 1);
                    nxt_v  = 1'b0;
                    dir_v  = 1'b0;
                end
                default: begin
                    busy_v = (t >= 2 && t <= s);
                    dir_v  = (t >= s && t <= s + h - 1);
                    nxt_v  = (t > s) && dir_v && 1'($urandom_range(0, 1));
                end
            endcase
            stp_v = 1'($urandom_range(0, 1));
            if (e == 1'b0) begin
                rd_busy = busy_v; rd_dout = e_dout; rd_stp = stp_v;
                wr_busy = 1'b0; wr_dout = 8'($urandom); wr_stp = 1'($urandom_range(0, 1));
            end else begin
                wr_busy = busy_v; wr_dout = e_dout; wr_stp = stp_v;
                rd_busy = 1'b0; rd_dout = 8'($urandom); rd_stp = 1'($urandom_range(0, 1));
            end
            DIR = dir_v; NXT = nxt_v; ULPI_DATA_IN = 8'($urandom);
            in_grant  = (mode == 0) ? (t >= 1 && t <= bl + 2) :
                        (mode == 1) ? (t >= 1 && t <= T) : (t >= 1 && t <= s);
            abort_cyc = (mode == 2) && (t == s);
            tmo_cyc   = (mode == 1) && (t == T + 1);
            exp_dout  = (in_grant && !abort_cyc) ? e_dout : 8'h00;
            cap       = (mode == 2) && (t >= s + 2) && dir_v && !nxt_v;
            step(exp_dout, in_grant ? stp_v : tmo_cyc, abort_cyc || tmo_cyc,
                 (t == 1) && !e, (t == 1) && e, cap);
            if (tmo_cyc) tmo_m = 1'b1;
        end
        if (mode == 0) begin
            ptr_wr_m = ~ptr_wr_m;
            if (e) want_wr = 1'b0;
            else   want_rd = 1'b0;
        end
    endtask

    // PHY takes the idle link for h cycles; pending requests must wait.
    task automatic phy_scn();
        int   h;
        logic cap;
        h = $urandom_range(1, 5);
        for (int t = 0; t < h + 2; t++) begin
            @(posedge clk); #1;
            rd_req = want_rd; wr_req = want_wr;
            rd_busy = 1'b0; wr_busy = 1'b0;
            rd_dout = 8'($urandom); wr_dout = 8'($urandom);
            rd_stp = 1'($urandom_range(0, 1)); wr_stp = 1'($urandom_range(0, 1));
            DIR = (t <= h - 1);
            NXT = DIR && (t >= 1) && 1'($urandom_range(0, 1));
            ULPI_DATA_IN = 8'($urandom);
            cap = (t >= 2) && DIR && !NXT;
            step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, cap);
        end
    endtask

    task automatic idle_scn();
        int n;
        n = $urandom_range(1, 3);
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            zero_inputs();
            rd_dout = 8'($urandom); wr_dout = 8'($urandom);
            rd_stp = 1'($urandom_range(0, 1)); ULPI_DATA_IN = 8'($urandom);
            step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int r;
        // reset state with busy-looking inputs
        zero_inputs();
        rd_req = 1'b1; wr_req = 1'b1; DIR = 1'b1; rd_dout = 8'hFF; wr_dout = 8'hEE;
        rd_stp = 1'b1; wr_stp = 1'b1; ULPI_DATA_IN = 8'h55;
        #12;
        check("rst_pins", 32'({ULPI_DATA_OUT, STP}), 32'd0);
        check("rst_ctrl", 32'({eng_abort, rd_start, wr_start, timeout_err}), 32'd0);
        check("rst_rx", 32'({rxcmd, rxcmd_valid}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        zero_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) want_rd = 1'b0;
            if ($urandom_range(0, 15) == 0) want_wr = 1'b0;
            if ($urandom_range(0, 2) == 0) want_rd = 1'b1;
            if ($urandom_range(0, 2) == 0) want_wr = 1'b1;
            r = $urandom_range(0, 8);
            if (r < 6) begin
                if (!want_rd && !want_wr) begin
                    if ($urandom_range(0, 1) == 0) want_rd = 1'b1;
                    else                          want_wr = 1'b1;
                end
                engine_scn();
            end else if (r < 8) begin
                phy_scn();
            end else begin
                idle_scn();
            end
        end

        // asynchronous reset in the middle of a write grant
        @(posedge clk); #1;
        zero_inputs();
        wr_req = 1'b1; wr_dout = 8'hA5; wr_stp = 1'b1; rd_dout = 8'h3C;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        check("ar_grant", 32'({ULPI_DATA_OUT, STP, wr_start}), 32'({8'hA5, 1'b1, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pins", 32'({ULPI_DATA_OUT, STP, eng_abort, wr_start}), 32'd0);
        check("ar_state", 32'(dbg_state), 32'd0);
        check("ar_rx", 32'({rxcmd, rxcmd_valid, timeout_err}), 32'd0);
        rd_req = 1'b1; wr_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        // pointer is back on READ, so the read engine wins the tie
        check("ar_rr", 32'({rd_start, wr_start, ULPI_DATA_OUT}), 32'({1'b1, 1'b0, 8'h3C}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
